// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter between NUM_UNITS functional units and the
// single register file write port.
//
// Each unit pushes its result into a private FIFO. One entry per cycle
// is popped under round-robin arbitration and written to the register file
// one cycle later through registered outputs.
//
// Handshake: in_oper[i] is a one-cycle valid strobe with no ready. The issue
// stage must hold off unit i while in_afull[i] is high. A qualifying push
// that arrives while channel i is full is dropped and latches ovf_err[i].
// wb_reg_en is a pure valid with no backpressure: the register file accepts
// every write.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   in_oper           per-channel result strobe
//   in_writereg       per-channel "result writes a register" flag
//   in_regdest        flattened 5-bit destination registers, channel i at [5i+4:5i]
//   in_wbvalue        flattened result data, channel i at [DATA_W*i +: DATA_W]
//   in_afull          per-channel occupancy >= AFULL_LEVEL
//   in_full           per-channel occupancy == FIFO_DEPTH
//   ovf_err           sticky per-channel overflow, cleared only by reset
//   wb_reg_en         register file write enable
//   wb_reg_addr       register file write address
//   wb_reg_data       register file write data
//   wb_reg_src        channel that produced the current write
module wb_arbiter #(
  parameter int NUM_UNITS   = 3,
  parameter int CH_W        = 2,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int PTR_W       = 2,
  parameter int AFULL_LEVEL = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_UNITS-1:0]        in_oper,
  input  logic [NUM_UNITS-1:0]        in_writereg,
  input  logic [5*NUM_UNITS-1:0]      in_regdest,
  input  logic [DATA_W*NUM_UNITS-1:0] in_wbvalue,
  output logic [NUM_UNITS-1:0]        in_afull,
  output logic [NUM_UNITS-1:0]        in_full,
  output logic [NUM_UNITS-1:0]        ovf_err,
  output logic                        wb_reg_en,
  output logic [4:0]                  wb_reg_addr,
  output logic [DATA_W-1:0]           wb_reg_data,
  output logic [CH_W-1:0]             wb_reg_src
);

  localparam int ENTRY_W = 5 + DATA_W;
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   AFULL_CNT = (PTR_W+1)'(AFULL_LEVEL);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CH_W-1:0]  LAST_RST  = CH_W'(NUM_UNITS-1);

  // Entry layout: {regdest[4:0], data[DATA_W-1:0]}
  logic [ENTRY_W-1:0] mem    [NUM_UNITS][FIFO_DEPTH];
  logic [PTR_W:0]     count  [NUM_UNITS];
  logic [PTR_W-1:0]   rd_ptr [NUM_UNITS];
  logic [PTR_W-1:0]   wr_ptr [NUM_UNITS];
  logic [CH_W-1:0]    last;

  logic [NUM_UNITS-1:0] qual;
  logic [NUM_UNITS-1:0] push;
  logic [NUM_UNITS-1:0] pop;
  logic [NUM_UNITS-1:0] ovf_set;
  logic                 gnt_valid;
  logic [CH_W-1:0]      gnt_idx;
  logic [CH_W-1:0]      cand_idx;
  logic [ENTRY_W-1:0]   head;
  int                   cand;

  // Push qualification and flags, all from the pre-edge count. A push onto
  // a full channel is dropped even if that channel pops this same cycle.
  always_comb begin
    qual     = '0;
    push     = '0;
    ovf_set  = '0;
    in_full  = '0;
    in_afull = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      qual[i]     = in_oper[i] & in_writereg[i] & (in_regdest[5*i +: 5] != 5'd0);
      in_full[i]  = (count[i] == FULL_CNT);
      in_afull[i] = (count[i] >= AFULL_CNT);
      push[i]     = qual[i] & ~in_full[i];
      ovf_set[i]  = qual[i] & in_full[i];
    end
  end

  // Round-robin: first non-empty channel scanning upward from last+1.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_UNITS; k++) begin
      cand = int'(last) + k;
      if (cand >= NUM_UNITS) cand = cand - NUM_UNITS;
      cand_idx = CH_W'(cand);
      if (!gnt_valid && (count[cand_idx] != '0)) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      pop[i] = gnt_valid && (gnt_idx == CH_W'(i));
    end
    head = mem[gnt_idx][rd_ptr[gnt_idx]];
  end

  // FIFO storage carries no reset; pointers and counts define validity.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {in_regdest[5*i +: 5], in_wbvalue[DATA_W*i +: DATA_W]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      ovf_err     <= '0;
      last        <= LAST_RST;
      wb_reg_en   <= 1'b0;
      wb_reg_addr <= '0;
      wb_reg_data <= '0;
      wb_reg_src  <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
        if (push[i] && !pop[i])      count[i] <= count[i] + CNT_ONE;
        else if (pop[i] && !push[i]) count[i] <= count[i] - CNT_ONE;
        if (ovf_set[i]) ovf_err[i] <= 1'b1;
      end
      // Address, data and source hold their last values when idle.
      wb_reg_en <= gnt_valid;
      if (gnt_valid) begin
        wb_reg_addr <= head[ENTRY_W-1 -: 5];
        wb_reg_data <= head[DATA_W-1:0];
        wb_reg_src  <= gnt_idx;
        last        <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  localparam int N     = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [N-1:0]    in_oper;
  logic [N-1:0]    in_writereg;
  logic [5*N-1:0]  in_regdest;
  logic [DW*N-1:0] in_wbvalue;
  logic [N-1:0]    in_afull;
  logic [N-1:0]    in_full;
  logic [N-1:0]    ovf_err;
  logic            wb_reg_en;
  logic [4:0]      wb_reg_addr;
  logic [DW-1:0]   wb_reg_data;
  logic [1:0]      wb_reg_src;

  wb_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .in_oper     (in_oper),
    .in_writereg (in_writereg),
    .in_regdest  (in_regdest),
    .in_wbvalue  (in_wbvalue),
    .in_afull    (in_afull),
    .in_full     (in_full),
    .ovf_err     (ovf_err),
    .wb_reg_en   (wb_reg_en),
    .wb_reg_addr (wb_reg_addr),
    .wb_reg_data (wb_reg_data),
    .wb_reg_src  (wb_reg_src)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One queue of {regdest, data} per channel; the head is the oldest entry.
  logic [36:0] exp_q [N][$];
  logic [N-1:0] m_ovf;
  logic         m_en;
  logic [4:0]   m_addr;
  logic [31:0]  m_data;
  int           m_src;
  int           m_last;
  bit           model_on = 1'b0;
  logic [N-1:0] m_acc;
  int           m_g;
  logic [36:0]  m_e;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) exp_q[i].delete();
      m_ovf = '0; m_en = 1'b0; m_addr = '0; m_data = '0; m_src = 0;
      m_last = N - 1;
      model_on = 1'b1;
    end else if (model_on) begin
      m_g = -1;
      for (int k = 1; k <= N; k++)
        if (m_g < 0 && exp_q[(m_last + k) % N].size() > 0) m_g = (m_last + k) % N;
      for (int i = 0; i < N; i++) begin
        m_acc[i] = in_oper[i] && in_writereg[i] && (in_regdest[5*i +: 5] != 5'd0);
        if (m_acc[i] && exp_q[i].size() == DEPTH) begin
          m_acc[i] = 1'b0;
          m_ovf[i] = 1'b1;
        end
      end
      if (m_g >= 0) begin
        m_e    = exp_q[m_g].pop_front();
        m_en   = 1'b1;
        m_addr = m_e[36:32];
        m_data = m_e[31:0];
        m_src  = m_g;
        m_last = m_g;
      end else begin
        m_en = 1'b0;
      end
      for (int i = 0; i < N; i++)
        if (m_acc[i]) exp_q[i].push_back({in_regdest[5*i +: 5], in_wbvalue[DW*i +: DW]});
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [N-1:0] e_full;
  logic [N-1:0] e_afull;
  always @(negedge clock) begin
    if (model_on) begin
      for (int i = 0; i < N; i++) begin
        e_full[i]  = (exp_q[i].size() == DEPTH);
        e_afull[i] = (exp_q[i].size() >= AFULL);
      end
      check("wb_reg_en",   32'(wb_reg_en),   32'(m_en));
      check("wb_reg_addr", 32'(wb_reg_addr), 32'(m_addr));
      check("wb_reg_data", wb_reg_data,      m_data);
      check("wb_reg_src",  32'(wb_reg_src),  32'(m_src));
      check("in_full",     32'(in_full),     32'(e_full));
      check("in_afull",    32'(in_afull),    32'(e_afull));
      check("ovf_err",     32'(ovf_err),     32'(m_ovf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clear_in();
    in_oper = '0; in_writereg = '0; in_regdest = '0; in_wbvalue = '0;
  endtask

  task automatic set_ch(input int ch, input logic wr, input logic [4:0] rd, input logic [31:0] d);
    in_oper[ch]            = 1'b1;
    in_writereg[ch]        = wr;
    in_regdest[5*ch +: 5]  = rd;
    in_wbvalue[DW*ch +: DW] = d;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    clear_in();
    for (int k = 0; k < 3 * DEPTH + 4; k++) tick();
  endtask

  task automatic single_push_test(input string tag);
    clear_in();
    set_ch(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    clear_in();
    check({tag, "_idle_en"}, 32'(wb_reg_en), 32'd0);
    tick();
    check({tag, "_en"},   32'(wb_reg_en),   32'd1);
    check({tag, "_addr"}, 32'(wb_reg_addr), 32'd5);
    check({tag, "_data"}, wb_reg_data,      32'hDEAD_BEEF);
    check({tag, "_src"},  32'(wb_reg_src),  32'd1);
    tick();
    check({tag, "_en_off"},    32'(wb_reg_en),   32'd0);
    check({tag, "_addr_hold"}, 32'(wb_reg_addr), 32'd5);
  endtask

  int  gcnt [N];
  int  n2;
  bit  seen3;
  bit  seen_bad;
  int  dens;

  initial begin
    clear_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_en",    32'(wb_reg_en),   32'd0);
    check("rst_addr",  32'(wb_reg_addr), 32'd0);
    check("rst_data",  wb_reg_data,      32'd0);
    check("rst_src",   32'(wb_reg_src),  32'd0);
    check("rst_full",  32'(in_full),     32'd0);
    check("rst_afull", 32'(in_afull),    32'd0);
    check("rst_ovf",   32'(ovf_err),     32'd0);

    // Single push on channel 1.
    single_push_test("single");

    // Simultaneous bursts: order 0,1,2 both times.
    do_reset();
    for (int b = 0; b < 2; b++) begin
      clear_in();
      set_ch(0, 1'b1, 5'd1, 32'h100 + 32'(b));
      set_ch(1, 1'b1, 5'd2, 32'h200 + 32'(b));
      set_ch(2, 1'b1, 5'd3, 32'h300 + 32'(b));
      tick();
      clear_in();
      for (int k = 0; k < 3; k++) begin
        tick();
        check("burst_en",   32'(wb_reg_en),   32'd1);
        check("burst_src",  32'(wb_reg_src),  32'(k));
        check("burst_addr", 32'(wb_reg_addr), 32'(k + 1));
      end
      tick();
      check("burst_idle", 32'(wb_reg_en), 32'd0);
    end

    // All channels kept busy for 12 grants: strict rotation, 4 each.
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    for (int c = 0; c <= 12; c++) begin
      clear_in();
      for (int i = 0; i < N; i++)
        if (exp_q[i].size() < 2) set_ch(i, 1'b1, 5'(8 + i), $urandom);
      tick();
      if (c >= 1) begin
        check("rot_en",  32'(wb_reg_en),  32'd1);
        check("rot_src", 32'(wb_reg_src), 32'((c - 1) % 3));
        if (int'(wb_reg_src) < N) gcnt[wb_reg_src]++;
      end
    end
    for (int i = 0; i < N; i++) check("rot_count", 32'(gcnt[i]), 32'd4);
    drain();

    // Fill channel 2 while channels 0/1 stay busy, then overflow it.
    seen3 = 1'b0;
    n2 = 0;
    for (int c = 0; c < 30 && exp_q[2].size() < DEPTH; c++) begin
      clear_in();
      for (int i = 0; i < 2; i++)
        if (exp_q[i].size() < 2) set_ch(i, 1'b1, 5'(10 + i), $urandom);
      set_ch(2, 1'b1, 5'd7, 32'h2000_0000 + 32'(n2));
      n2++;
      tick();
      if (exp_q[2].size() == 3 && !seen3) begin
        seen3 = 1'b1;
        check("afull_at3", 32'(in_afull[2]), 32'd1);
        check("full_at3",  32'(in_full[2]),  32'd0);
      end
    end
    check("full_at4",  32'(in_full[2]),  32'd1);
    check("afull_at4", 32'(in_afull[2]), 32'd1);
    check("ovf_pre",   32'(ovf_err[2]),  32'd0);
    clear_in();
    for (int i = 0; i < 2; i++)
      if (exp_q[i].size() < 2) set_ch(i, 1'b1, 5'(10 + i), $urandom);
    set_ch(2, 1'b1, 5'd31, BAD);
    tick();
    clear_in();
    check("ovf_set", 32'(ovf_err[2]), 32'd1);
    seen_bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (wb_reg_en && wb_reg_data == BAD) seen_bad = 1'b1;
    end
    check("ovf_dropped", 32'(seen_bad),   32'd0);
    check("ovf_sticky",  32'(ovf_err[2]), 32'd1);

    // Silent drops: regdest 0 and writereg 0.
    clear_in();
    set_ch(0, 1'b1, 5'd0, 32'h1111_1111);
    set_ch(1, 1'b0, 5'd9, 32'h2222_2222);
    tick();
    clear_in();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("drop_en", 32'(wb_reg_en), 32'd0);
    end
    check("drop_ovf",   32'(ovf_err),  32'b100);
    check("drop_afull", 32'(in_afull), 32'd0);

    // Reset mid-drain on channel 0.
    for (int k = 0; k < 3; k++) begin
      clear_in();
      set_ch(0, 1'b1, 5'(20 + k), 32'h3000_0000 + 32'(k));
      tick();
    end
    do_reset();
    check("mid_rst_en",    32'(wb_reg_en),   32'd0);
    check("mid_rst_addr",  32'(wb_reg_addr), 32'd0);
    check("mid_rst_data",  wb_reg_data,      32'd0);
    check("mid_rst_ovf",   32'(ovf_err),     32'd0);
    check("mid_rst_full",  32'(in_full),     32'd0);
    check("mid_rst_afull", 32'(in_afull),    32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_en", 32'(wb_reg_en), 32'd0);
    end
    single_push_test("after_rst");

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      case (c / 300)
        0: dens = 20;
        1: dens = 50;
        2: dens = 90;
        3: dens = 35;
        default: dens = 70;
      endcase
      clear_in();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 99) < dens)
          set_ch(i, $urandom_range(0, 9) != 0,
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 $urandom);
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Parametrised writeback arbiter between N functional units (ALU/misc, memory, multiplier, and future units) and the register file write port.
- Each unit's result is buffered in a per-unit FIFO.
- One result per cycle drains to the register file under round-robin arbitration.
- Per-unit almost-full flags feed the issue stage stall, so a unit is never issued to when its writeback slot cannot be guaranteed.

Parameters:
- NUM_UNITS, 3, number of result channels (functional units).
- CH_W, 2, width of channel index; must satisfy 2^CH_W >= NUM_UNITS.
- DATA_W, 32, result data width.
- FIFO_DEPTH, 4, entries per channel FIFO; power of two.
- PTR_W, 2, log2(FIFO_DEPTH).
- AFULL_LEVEL, 3, occupancy at or above which in_afull is raised.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_oper  in  NUM_UNITS  per-channel result-valid strobe; bit i belongs to unit i.
- in_writereg  in  NUM_UNITS  per-channel "result writes a register" flag.
- in_regdest  in  5*NUM_UNITS  flattened destination register numbers; channel i occupies [5i+4:5i].
- in_wbvalue  in  DATA_W*NUM_UNITS  flattened result data; channel i occupies [DATA_W*i+DATA_W-1:DATA_W*i].
- in_afull  out  NUM_UNITS  per-channel almost-full, driven to issue stall logic.
- in_full  out  NUM_UNITS  per-channel full.
- ovf_err  out  NUM_UNITS  sticky per-channel overflow (push while full).
- wb_reg_en  out  1  register file write enable.
- wb_reg_addr  out  5  register file write address.
- wb_reg_data  out  DATA_W  register file write data.
- wb_reg_src  out  CH_W  index of the channel that produced the current write.

Behaviour:
- Reset (synchronous, active-high):
  - All FIFOs empty, so counts, read pointers and write pointers are 0.
  - in_full = 0, in_afull = 0, ovf_err = 0.
  - wb_reg_en = 0, wb_reg_addr = 0, wb_reg_data = 0, wb_reg_src = 0.
  - Round-robin pointer last = NUM_UNITS-1, so channel 0 has priority first.
  - Reset asserted mid-operation discards all buffered entries; no write is issued in the cycle after reset.
- Enqueue on channel i at a rising edge:
  - Occurs when in_oper[i]=1, in_writereg[i]=1, in_regdest[i]!=0 and count_i < FIFO_DEPTH.
  - The entry is {regdest, wbvalue}.
- Silent drops (no enqueue, no error):
  - in_oper[i]=1 with in_writereg[i]=0.
  - in_oper[i]=1 with regdest=0.
- Overflow:
  - A qualifying push while count_i == FIFO_DEPTH is dropped and sets ovf_err[i]=1.
  - ovf_err[i] is cleared only by reset.
  - Full is evaluated on the pre-edge count. A push onto a full channel is dropped even if that channel is granted in the same cycle (no pass-through).
- Flags (combinational from the registered count):
  - in_full[i] = (count_i == FIFO_DEPTH).
  - in_afull[i] = (count_i >= AFULL_LEVEL).
- Arbitration (each cycle):
  - Requesters are the channels with count_i > 0.
  - Grant goes to the first requester found scanning from last+1 upward, wrapping modulo NUM_UNITS.
  - On a grant, the head entry is popped and last is set to the granted index.
  - With no requesters, last holds.
- Outputs:
  - Registered with 1-cycle latency: a grant at edge t drives wb_reg_en=1, addr, data and src during cycle t+1.
  - With no grant, wb_reg_en=0 and addr/data/src hold their previous values.
- Minimum latency: an entry pushed into an empty channel at edge t can be granted at edge t+1, so its write is visible from t+1 to t+2.
- Simultaneous push and pop on one channel: count unchanged, and both pointers advance and wrap modulo FIFO_DEPTH.
- Ordering: entries from one channel retire in FIFO order. There is no ordering guarantee across channels; the issue stage is responsible for WAW hazards.
- Throughput: 1 write per cycle total. With all channels continuously busy, each channel retires once every NUM_UNITS cycles.

Test Plan:
- Reset, then a single push on ch1 (regdest=5, data=0xDEADBEEF) -> two cycles later wb_reg_en=1, addr=5, data=0xDEADBEEF, src=1; wb_reg_en=0 on the following cycle.
- Push on ch0/ch1/ch2 in the same cycle (regdest 1/2/3) -> writes appear on consecutive cycles in order ch0, ch1, ch2; the next simultaneous burst also starts at ch0, since last=2 wraps to 0.
- Keep all channels non-empty for 12 cycles -> grants rotate 0,1,2,0,... with exactly 4 grants per channel.
- Push 4 entries on ch2 while ch0 and ch1 are held busy -> in_afull[2]=1 at count 3 and in_full[2]=1 at count 4; a 5th push sets ovf_err[2]=1, the entry is absent from the output, and ovf_err[2] stays 1 until reset.
- Push with regdest=0, and separately with writereg=0 -> no FIFO occupancy change, no write, no error.
- Fill ch0 with 3 entries, assert reset for 1 cycle mid-drain -> no further writes, flags 0, and a subsequent push behaves as in the first scenario.
